// File: rtl/dpram_line_writer_pkg.sv
// Shared constants, FSM encoding and helpers for the line-buffer write side.
// Optional statistics are enabled with DPRAM_LINE_WRITER_STATS_EN.
package dpram_line_writer_pkg;

  localparam int DPRAM_ADDR_W = 11;
  localparam int DPRAM_BANK_W = 10;
  localparam int DPRAM_WR_W   = 2;
  localparam int DPRAM_RD_W   = 16;
  localparam int DPRAM_LEN_W  = 11;
  localparam int DPRAM_NUM_W  = 12;
  localparam int DPRAM_DROP_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SKIP  = 2'd2,
    ST_WRITE = 2'd3
  } wr_state_e;

  function automatic logic [DPRAM_DROP_W-1:0] sat_inc16(input logic [DPRAM_DROP_W-1:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dpram_bank_guard.sv
// Ping-pong bank ownership: bank bit, claim check against rd_busy, overflow and drop count.
// drop_count is live only when DPRAM_LINE_WRITER_STATS_EN is defined.
module dpram_bank_guard
  import dpram_line_writer_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear_i,
  input  logic                    toggle_i,
  input  logic                    claim_i,
  input  logic [1:0]              rd_busy_i,
  output logic                    bank_o,
  output logic                    bank_next_o,
  output logic                    claim_ok_o,
  output logic                    overflow_o,
  output logic [DPRAM_DROP_W-1:0] drop_count_o
);

  logic bank_q, bank_d;
  logic overflow_q, overflow_d;
  logic drop_s;

  // A line closing this cycle hands the next claim the other bank.
  assign bank_next_o = bank_q ^ toggle_i;
  assign claim_ok_o  = ~rd_busy_i[bank_next_o];
  assign drop_s      = claim_i & ~claim_ok_o;
  assign bank_o      = bank_q;
  assign overflow_o  = overflow_q;

  always_comb begin
    bank_d     = bank_q;
    overflow_d = overflow_q;
    if (clear_i) begin
      bank_d     = 1'b0;
      overflow_d = 1'b0;
    end else begin
      bank_d = bank_next_o;
      if (drop_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      bank_q     <= bank_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef DPRAM_LINE_WRITER_STATS_EN
  logic [DPRAM_DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    if (drop_s) begin
      drop_cnt_d = sat_inc16(drop_cnt_q);
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Cleared by reset only; frame starts leave the count alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_q <= 16'h0000;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count_o = drop_cnt_q;
`else
  assign drop_count_o = 16'h0000;
`endif

endmodule

// File: rtl/dpram_line_writer.sv
// Write-side sequencer for the 2b-write / 16b-read ping-pong line buffer RAM.
// Optional drop statistics: define DPRAM_LINE_WRITER_STATS_EN.
module dpram_line_writer
  import dpram_line_writer_pkg::*;
#(
  parameter int H_SKIP   = 16,
  parameter int H_ACTIVE = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [DPRAM_WR_W-1:0]   in_data,
  input  logic                    in_hsync,
  input  logic                    in_vsync,
  input  logic [1:0]              rd_busy,
  output logic                    wr_enable,
  output logic [DPRAM_ADDR_W-1:0] wr_addr,
  output logic [DPRAM_WR_W-1:0]   wr_data,
  output logic                    line_ready,
  output logic                    line_bank,
  output logic [DPRAM_LEN_W-1:0]  line_len,
  output logic [DPRAM_NUM_W-1:0]  line_num,
  output logic                    overflow,
  output logic [DPRAM_DROP_W-1:0] drop_count
);

  localparam logic [15:0]            SKIP_LAST = 16'(H_SKIP - 1);
  localparam logic [DPRAM_LEN_W-1:0] ACT_MAX   = 11'(H_ACTIVE);
  localparam bit                     NO_SKIP   = (H_SKIP == 0);
  localparam bit                     ONE_SKIP  = (H_SKIP == 1);

  wr_state_e               state_q, state_d;
  logic [15:0]             skip_cnt_q, skip_cnt_d;
  logic [DPRAM_LEN_W-1:0]  idx_q, idx_d;
  logic [DPRAM_NUM_W-1:0]  line_cnt_q, line_cnt_d;
  logic                    wr_enable_q, wr_enable_d;
  logic [DPRAM_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DPRAM_WR_W-1:0]   wr_data_q, wr_data_d;
  logic                    line_ready_q, line_ready_d;
  logic                    line_bank_q, line_bank_d;
  logic [DPRAM_LEN_W-1:0]  line_len_q, line_len_d;
  logic [DPRAM_NUM_W-1:0]  line_num_q, line_num_d;

  logic close_s, toggle_s, claim_s, start_s;
  logic bank_s, bank_next_s, claim_ok_s;

  // Closing is decided outside the FSM process so the claim can see the toggled bank.
  assign close_s  = (state_q == ST_WRITE) && !in_vsync && (in_hsync || (idx_q == ACT_MAX));
  assign toggle_s = close_s && (idx_q != 11'd0);

  dpram_bank_guard u_guard (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (in_vsync),
    .toggle_i     (toggle_s),
    .claim_i      (claim_s),
    .rd_busy_i    (rd_busy),
    .bank_o       (bank_s),
    .bank_next_o  (bank_next_s),
    .claim_ok_o   (claim_ok_s),
    .overflow_o   (overflow),
    .drop_count_o (drop_count)
  );

  always_comb begin
    state_d      = state_q;
    skip_cnt_d   = skip_cnt_q;
    idx_d        = idx_q;
    line_cnt_d   = line_cnt_q;
    wr_enable_d  = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    line_ready_d = 1'b0;
    line_bank_d  = line_bank_q;
    line_len_d   = line_len_q;
    line_num_d   = line_num_q;
    claim_s      = 1'b0;
    start_s      = 1'b0;

    if (in_vsync) begin
      state_d    = ST_WAIT;
      line_cnt_d = 12'd0;
      idx_d      = 11'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_WAIT: begin
          if (in_hsync) begin
            start_s = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_SKIP: begin
          if (in_hsync) begin
            start_s = 1'b1;
          end else if (in_valid) begin
            if (skip_cnt_q == SKIP_LAST) begin
              claim_s = 1'b1;
              idx_d   = 11'd0;
              state_d = claim_ok_s ? ST_WRITE : ST_WAIT;
            end else begin
              skip_cnt_d = skip_cnt_q + 16'd1;
            end
          end else begin
            state_d = ST_SKIP;
          end
        end
        ST_WRITE: begin
          if (close_s) begin
            if (toggle_s) begin
              line_ready_d = 1'b1;
              line_bank_d  = bank_s;
              line_len_d   = idx_q;
              line_num_d   = line_cnt_q;
              line_cnt_d   = line_cnt_q + 12'd1;
            end else begin
              line_ready_d = 1'b0;
            end
            if (in_hsync) begin
              start_s = 1'b1;
            end else begin
              state_d = ST_WAIT;
            end
          end else if (in_valid) begin
            wr_enable_d = 1'b1;
            wr_addr_d   = {bank_next_s, idx_q[DPRAM_BANK_W-1:0]};
            wr_data_d   = in_data;
            idx_d       = idx_q + 11'd1;
          end else begin
            state_d = ST_WRITE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      // New line: the hsync-cycle sample is already sample 0 of it.
      if (start_s) begin
        idx_d = 11'd0;
        if (NO_SKIP) begin
          claim_s = 1'b1;
          state_d = claim_ok_s ? ST_WRITE : ST_WAIT;
          if (claim_ok_s && in_valid) begin
            wr_enable_d = 1'b1;
            wr_addr_d   = {bank_next_s, 10'd0};
            wr_data_d   = in_data;
            idx_d       = 11'd1;
          end else begin
            idx_d = 11'd0;
          end
        end else if (ONE_SKIP && in_valid) begin
          claim_s = 1'b1;
          state_d = claim_ok_s ? ST_WRITE : ST_WAIT;
        end else begin
          state_d    = ST_SKIP;
          skip_cnt_d = {15'd0, in_valid};
        end
      end else begin
        start_s = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      skip_cnt_q   <= 16'd0;
      idx_q        <= 11'd0;
      line_cnt_q   <= 12'd0;
      wr_enable_q  <= 1'b0;
      wr_addr_q    <= 11'd0;
      wr_data_q    <= 2'd0;
      line_ready_q <= 1'b0;
      line_bank_q  <= 1'b0;
      line_len_q   <= 11'd0;
      line_num_q   <= 12'd0;
    end else begin
      state_q      <= state_d;
      skip_cnt_q   <= skip_cnt_d;
      idx_q        <= idx_d;
      line_cnt_q   <= line_cnt_d;
      wr_enable_q  <= wr_enable_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      line_ready_q <= line_ready_d;
      line_bank_q  <= line_bank_d;
      line_len_q   <= line_len_d;
      line_num_q   <= line_num_d;
    end
  end

  assign wr_enable  = wr_enable_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign line_ready = line_ready_q;
  assign line_bank  = line_bank_q;
  assign line_len   = line_len_q;
  assign line_num   = line_num_q;

endmodule

// File: tb/tb_dpram_line_writer.sv
// Directed bench for dpram_line_writer with a line-level reference model and literal pins.
module tb_dpram_line_writer;

  localparam int HS = 2;
  localparam int HA = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [1:0]  in_data = 2'd0;
  logic        in_hsync = 1'b0;
  logic        in_vsync = 1'b0;
  logic [1:0]  rd_busy = 2'b00;
  logic        wr_enable;
  logic [10:0] wr_addr;
  logic [1:0]  wr_data;
  logic        line_ready;
  logic        line_bank;
  logic [10:0] line_len;
  logic [11:0] line_num;
  logic        overflow;
  logic [15:0] drop_count;

  always #5 clk = ~clk;

  dpram_line_writer #(.H_SKIP(HS), .H_ACTIVE(HA)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .rd_busy(rd_busy),
    .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data),
    .line_ready(line_ready), .line_bank(line_bank), .line_len(line_len),
    .line_num(line_num), .overflow(overflow), .drop_count(drop_count)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: frame/line progress in plain terms.
  bit m_framed, m_skipping, m_writing, m_ovf;
  int m_skip_left, m_written, m_bank, m_line, m_drops;
  bit e_we, e_rdy;
  int e_addr, e_data, e_rbank, e_len, e_num;

  function automatic void m_claim(input logic [1:0] busy);
    m_skipping = 1'b0;
    if (busy[m_bank]) begin
      m_ovf = 1'b1;
      if (m_drops < 65535) m_drops++;
    end else begin
      m_writing = 1'b1;
      m_written = 0;
    end
  endfunction

  function automatic void m_write(input logic [1:0] d);
    e_we = 1'b1;
    e_addr = m_bank * 1024 + m_written;
    e_data = int'(d);
    m_written++;
  endfunction

  function automatic void model_step(input bit v, input logic [1:0] d, input bit hs, input bit vs,
                                     input logic [1:0] busy);
    e_we = 1'b0;
    e_rdy = 1'b0;
    if (vs) begin
      m_framed = 1'b1; m_skipping = 1'b0; m_writing = 1'b0;
      m_bank = 0; m_line = 0; m_ovf = 1'b0;
    end else if (m_framed) begin
      if (m_writing) begin
        if (hs || m_written == HA) begin
          if (m_written > 0) begin
            e_rdy = 1'b1; e_rbank = m_bank; e_len = m_written; e_num = m_line;
            m_bank = 1 - m_bank;
            m_line = (m_line + 1) % 4096;
          end
          m_writing = 1'b0;
        end else if (v) begin
          m_write(d);
        end
      end
      if (hs) begin
        m_writing = 1'b0;
        m_skipping = 1'b1;
        m_skip_left = HS;
        if (m_skip_left == 0) begin
          m_claim(busy);
          if (m_writing && v) m_write(d);
        end else if (v) begin
          m_skip_left--;
          if (m_skip_left == 0) m_claim(busy);
        end
      end else if (m_skipping && v) begin
        m_skip_left--;
        if (m_skip_left == 0) m_claim(busy);
      end
    end
  endfunction

  function automatic void model_reset();
    m_framed = 1'b0; m_skipping = 1'b0; m_writing = 1'b0; m_ovf = 1'b0;
    m_bank = 0; m_line = 0; m_drops = 0; m_written = 0;
    e_we = 1'b0; e_rdy = 1'b0;
  endfunction

  function automatic int exp_drops();
`ifdef DPRAM_LINE_WRITER_STATS_EN
    return m_drops;
`else
    return 0;
`endif
  endfunction

  // Captured DUT activity for the literal checks.
  logic [1:0] mem [0:2047];
  int wcount = 0, rcount = 0, last_bank = -1, last_len = -1, last_num = -1;
  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("wr_enable", int'(wr_enable), int'(e_we));
      if (e_we) begin
        check("wr_addr", int'(wr_addr), e_addr);
        check("wr_data", int'(wr_data), e_data);
      end
      check("line_ready", int'(line_ready), int'(e_rdy));
      if (e_rdy) begin
        check("line_bank", int'(line_bank), e_rbank);
        check("line_len", int'(line_len), e_len);
        check("line_num", int'(line_num), e_num);
      end
      check("overflow", int'(overflow), int'(m_ovf));
      check("drop_count", int'(drop_count), exp_drops());
      if (wr_enable) begin
        mem[wr_addr] = wr_data;
        wcount++;
      end
      if (line_ready) begin
        rcount++;
        last_bank = int'(line_bank);
        last_len = int'(line_len);
        last_num = int'(line_num);
      end
    end
  end

  task automatic step(input bit v, input logic [1:0] d, input bit hs, input bit vs);
    in_valid = v; in_data = d; in_hsync = hs; in_vsync = vs;
    @(posedge clk);
    model_step(v, d, hs, vs, rd_busy);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic samples(input int n, input int base);
    for (int i = 0; i < n; i++) step(1'b1, 2'(base + i), 1'b0, 1'b0);
  endtask

  task automatic hsync_only();
    step(1'b0, 2'd0, 1'b1, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " wr_enable"}, int'(wr_enable), 0);
    check({tag, " wr_addr"}, int'(wr_addr), 0);
    check({tag, " wr_data"}, int'(wr_data), 0);
    check({tag, " line_ready"}, int'(line_ready), 0);
    check({tag, " line_bank"}, int'(line_bank), 0);
    check({tag, " line_len"}, int'(line_len), 0);
    check({tag, " line_num"}, int'(line_num), 0);
    check({tag, " overflow"}, int'(overflow), 0);
    check({tag, " drop_count"}, int'(drop_count), 0);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic mid_reset();
    #2;
    reset = 1'b1;
    #1;
    check_zero("midrst");
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("inrst");
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc, rc;
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("reset");
    #2;
    reset = 1'b0;
    chk_en = 1'b1;

    // Hsync before the first vsync is ignored.
    hsync_only(); samples(12, 0); idle(2);
    #1; check("pre-vsync writes", wcount, 0);

    // Test 1: skip 2, write samples 2..9 to addr 0..7.
    step(1'b0, 2'd0, 1'b0, 1'b1); idle(2);
    hsync_only(); samples(12, 0); idle(3);
    #1;
    check("t1 rcount", rcount, 1);
    check("t1 wcount", wcount, 8);
    check("t1 len", last_len, 8);
    check("t1 bank", last_bank, 0);
    check("t1 num", last_num, 0);
    check("t1 mem0", int'(mem[0]), 2);
    check("t1 mem7", int'(mem[7]), 1);

    // Test 2: ping-pong across banks.
    hsync_only(); samples(12, 0); idle(3);
    #1;
    check("t2 bank", last_bank, 1);
    check("t2 num", last_num, 1);
    check("t2 mem1024", int'(mem[1024]), 2);
    hsync_only(); samples(12, 0); idle(3);
    #1;
    check("t2 bank back", last_bank, 0);
    check("t2 num2", last_num, 2);
    check("t2 wcount", wcount, 24);

    // Test 3: hsync with a valid sample after 5 active samples.
    hsync_only(); samples(7, 0);
    step(1'b1, 2'd3, 1'b1, 1'b0); idle(2);
    #1;
    check("t3 len", last_len, 5);
    check("t3 bank", last_bank, 1);
    check("t3 num", last_num, 3);
    samples(11, 0); idle(3);
    #1;
    check("t3 next len", last_len, 8);
    check("t3 next bank", last_bank, 0);
    check("t3 mem0", int'(mem[0]), 1);

    // Test 4: bank 1 busy at claim -> line dropped.
    wc = wcount; rc = rcount;
    rd_busy = 2'b10;
    hsync_only(); samples(12, 0); idle(2);
    #1;
    check("t4 overflow", int'(overflow), 1);
    check("t4 no writes", wcount, wc);
    check("t4 no ready", rcount, rc);
`ifdef DPRAM_LINE_WRITER_STATS_EN
    check("t4 drop_count", int'(drop_count), 1);
`else
    check("t4 drop_count", int'(drop_count), 0);
`endif
    rd_busy = 2'b00;
    hsync_only(); samples(4, 0);
    rd_busy = 2'b10;
    samples(8, 0); idle(3);
    rd_busy = 2'b00;
    #1;
    check("t4 retry bank", last_bank, 1);
    check("t4 retry num", last_num, 5);
    check("t4 retry wcount", wcount, wc + 8);
    check("t4 sticky", int'(overflow), 1);

    // Test 5: vsync mid-write aborts the line; vsync beats a same-cycle hsync.
    rc = rcount;
    hsync_only(); samples(5, 0);
    step(1'b0, 2'd0, 1'b0, 1'b1); idle(2);
    #1;
    check("t5 no ready", rcount, rc);
    check("t5 overflow clr", int'(overflow), 0);
    wc = wcount;
    step(1'b0, 2'd0, 1'b1, 1'b1); samples(12, 0); idle(2);
    #1;
    check("t5 vsync wins", wcount, wc);
    hsync_only(); samples(12, 0); idle(3);
    #1;
    check("t5 num", last_num, 0);
    check("t5 bank", last_bank, 0);
    check("t5 mem0", int'(mem[0]), 2);

    // Test 6: reset mid-write; nothing until vsync+hsync.
    rc = rcount;
    hsync_only(); samples(5, 0);
    mid_reset();
    wc = wcount;
    hsync_only(); samples(12, 0); idle(3);
    #1;
    check("t6 no writes", wcount, wc);
    check("t6 no ready", rcount, rc);
    step(1'b0, 2'd0, 1'b0, 1'b1);
    hsync_only(); samples(12, 0); idle(3);
    #1;
    check("t6 resumed", wcount, wc + 8);
    check("t6 num", last_num, 0);
    check("t6 bank", last_bank, 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
